// File: rtl/stage_ctrl_pkg.sv
// stage_ctrl_pkg: stage encodings and instruction-type codes shared by the
// sequencer, ALU and decode blocks.
package stage_ctrl_pkg;

    typedef enum logic [2:0] {
        STG_FETCH     = 3'd0,
        STG_DECODE    = 3'd1,
        STG_OPERAND   = 3'd2,
        STG_EXECUTE   = 3'd3,
        STG_WRITEBACK = 3'd4
    } stage_e;

    localparam logic [4:0] RTYPE = 5'h01;
    localparam logic [4:0] ITYPE = 5'h02;
    localparam logic [4:0] STYPE = 5'h03;
    localparam logic [4:0] UTYPE = 5'h04;

    function automatic logic writes_rf(input logic [4:0] t);
        return (t == RTYPE) || (t == ITYPE) || (t == UTYPE);
    endfunction

endpackage

// File: rtl/stage_ctrl.sv
// stage_ctrl: five-stage multi-cycle sequencer driving ALU strobes, RF/memory
// writes, PC increment and retire count. Define SINGLE_STEP_EN to add step_i gating.
module stage_ctrl
    import stage_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_valid_i,
    input  logic [4:0]  itype_i,
    input  logic        mem_ready_i,
    input  logic        halt_i,
`ifdef SINGLE_STEP_EN
    input  logic        step_i,
`endif
    output logic [2:0]  stage_o,
    output logic        fetch_req_o,
    output logic        readin_a_o,
    output logic        readin_b_o,
    output logic        readin_pass_o,
    output logic        rf_we_o,
    output logic        mem_we_o,
    output logic        pc_inc_o,
    output logic        illegal_o,
    output logic [31:0] retired_o
);

    stage_e      state_q, state_d;
    logic        readin_q, readin_d;
    logic        pass_q, pass_d;
    logic        rf_we_q, rf_we_d;
    logic        mem_we_q, mem_we_d;
    logic        pc_inc_q, pc_inc_d;
    logic        illegal_q, illegal_d;
    logic [31:0] retired_q, retired_d;
    logic        go, store_done, retire, in_wb;

`ifdef SINGLE_STEP_EN
    logic step_pend_q, step_pend_d;
    assign go = ir_valid_i && !halt_i && step_pend_q;
`else
    assign go = ir_valid_i && !halt_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            STG_FETCH:     state_d = go ? STG_DECODE : STG_FETCH;
            STG_DECODE:    state_d = STG_OPERAND;
            STG_OPERAND:   state_d = STG_EXECUTE;
            STG_EXECUTE:   state_d = STG_WRITEBACK;
            STG_WRITEBACK: state_d = (itype_i == STYPE && !mem_ready_i) ? STG_WRITEBACK : STG_FETCH;
            default:       state_d = STG_FETCH;
        endcase
        store_done  = (state_q == STG_WRITEBACK) && (itype_i == STYPE) && mem_ready_i;
        retire      = (state_q == STG_WRITEBACK) && (writes_rf(itype_i) || store_done);
        retired_d   = retired_q + {31'd0, retire};
        // Strobes are registered from the next state so each tracks its stage exactly.
        in_wb       = (state_d == STG_WRITEBACK);
        readin_d    = (state_d == STG_OPERAND);
        pass_d      = readin_d && (itype_i == STYPE);
        rf_we_d     = in_wb && writes_rf(itype_i);
        mem_we_d    = in_wb && (itype_i == STYPE);
        illegal_d   = in_wb && !writes_rf(itype_i) && (itype_i != STYPE);
        pc_inc_d    = (in_wb && (itype_i != STYPE)) || store_done;
    end

`ifdef SINGLE_STEP_EN
    always_comb begin
        step_pend_d = ((state_q == STG_FETCH) && go) ? 1'b0 : (step_pend_q | step_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) step_pend_q <= 1'b0;
        else       step_pend_q <= step_pend_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= STG_FETCH;
            readin_q  <= 1'b0;
            pass_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            mem_we_q  <= 1'b0;
            pc_inc_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            readin_q  <= readin_d;
            pass_q    <= pass_d;
            rf_we_q   <= rf_we_d;
            mem_we_q  <= mem_we_d;
            pc_inc_q  <= pc_inc_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Fetch request must follow halt_i within the FETCH cycle and stay low under reset.
    assign fetch_req_o   = (state_q == STG_FETCH) && !halt_i && !reset;
    assign stage_o       = state_q;
    assign readin_a_o    = readin_q;
    assign readin_b_o    = readin_q;
    assign readin_pass_o = pass_q;
    assign rf_we_o       = rf_we_q;
    assign mem_we_o      = mem_we_q;
    assign pc_inc_o      = pc_inc_q;
    assign illegal_o     = illegal_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// tb_stage_ctrl: directed bench for stage_ctrl with a cycle-level reference model
// and hand-computed expectations; covers SINGLE_STEP_EN when defined.
module tb_stage_ctrl;
    import stage_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ir_valid_i = 1'b0;
    logic [4:0]  itype_i = RTYPE;
    logic        mem_ready_i = 1'b0;
    logic        halt_i = 1'b0;
`ifdef SINGLE_STEP_EN
    logic        step_i = 1'b1;
`endif
    logic [2:0]  stage_o;
    logic        fetch_req_o, readin_a_o, readin_b_o, readin_pass_o;
    logic        rf_we_o, mem_we_o, pc_inc_o, illegal_o;
    logic [31:0] retired_o;

    int checks = 0;
    int failures = 0;

    stage_ctrl dut (
        .clk(clk),
        .reset(reset),
        .ir_valid_i(ir_valid_i),
        .itype_i(itype_i),
        .mem_ready_i(mem_ready_i),
        .halt_i(halt_i),
`ifdef SINGLE_STEP_EN
        .step_i(step_i),
`endif
        .stage_o(stage_o),
        .fetch_req_o(fetch_req_o),
        .readin_a_o(readin_a_o),
        .readin_b_o(readin_b_o),
        .readin_pass_o(readin_pass_o),
        .rf_we_o(rf_we_o),
        .mem_we_o(mem_we_o),
        .pc_inc_o(pc_inc_o),
        .illegal_o(illegal_o),
        .retired_o(retired_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_stage(input int s, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (32'(stage_o) == s) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout waiting for stage %0d, stage=%0d", s, stage_o);
    endtask

    // Reference model: stage number, retire count and the one-cycle store-completion flag.
    int          m_stage;
    logic [31:0] m_ret;
    logic        m_store_done;
    logic        m_pend;
    logic        m_leave;
    logic        m_known;

    assign m_known = (itype_i == RTYPE) || (itype_i == ITYPE) || (itype_i == UTYPE);
    assign m_leave = (m_stage == 0) && ir_valid_i && !halt_i && m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_stage      <= 0;
            m_ret        <= 32'd0;
            m_store_done <= 1'b0;
`ifdef SINGLE_STEP_EN
            m_pend       <= 1'b0;
`else
            m_pend       <= 1'b1;
`endif
        end else begin
            m_store_done <= (m_stage == 4) && (itype_i == STYPE) && mem_ready_i;
            if (m_stage == 4 && (m_known || (itype_i == STYPE && mem_ready_i)))
                m_ret <= m_ret + 32'd1;
            if (m_stage == 0)
                m_stage <= m_leave ? 1 : 0;
            else if (m_stage < 4)
                m_stage <= m_stage + 1;
            else
                m_stage <= (itype_i == STYPE && !mem_ready_i) ? 4 : 0;
`ifdef SINGLE_STEP_EN
            m_pend <= m_leave ? 1'b0 : (m_pend | step_i);
`endif
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("stage", 32'(stage_o), 32'(m_stage));
            chk("fetch_req", 32'(fetch_req_o), 32'(m_stage == 0 && !halt_i));
            chk("readin_a", 32'(readin_a_o), 32'(m_stage == 2));
            chk("readin_b", 32'(readin_b_o), 32'(m_stage == 2));
            chk("readin_pass", 32'(readin_pass_o), 32'(m_stage == 2 && itype_i == STYPE));
            chk("rf_we", 32'(rf_we_o), 32'(m_stage == 4 && m_known));
            chk("mem_we", 32'(mem_we_o), 32'(m_stage == 4 && itype_i == STYPE));
            chk("illegal", 32'(illegal_o), 32'(m_stage == 4 && !m_known && itype_i != STYPE));
            chk("pc_inc", 32'(pc_inc_o), 32'((m_stage == 4 && itype_i != STYPE) || m_store_done));
            chk("retired", retired_o, m_ret);
        end
    end

`ifdef SINGLE_STEP_EN
    task automatic pulse_step();
        @(posedge clk); #2 step_i = 1'b1;
        @(posedge clk); #2 step_i = 1'b0;
    endtask
`endif

    initial begin
        int lat, w, mw, pc, ps, ill, rf;
        bit done;
        ir_valid_i = 1'b1;
        itype_i = RTYPE;
        #3;
        chk("rst_stage", 32'(stage_o), 32'd0);
        chk("rst_fetch_req", 32'(fetch_req_o), 32'd0);
        chk("rst_retired", retired_o, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("first_fetch_req", 32'(fetch_req_o), 32'd1);

        // Back-to-back RTYPE: five-cycle period, three retirements.
        wait_stage(1, 10);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            chk("rt_seq", 32'(stage_o), 32'((i + 1) % 5));
            chk("rt_readin", 32'(readin_a_o), 32'(((i + 1) % 5) == 2));
            chk("rt_rf_we", 32'(rf_we_o), 32'(((i + 1) % 5) == 4));
        end
        chk("rt_retired3", retired_o, 32'd3);
        ir_valid_i = 1'b0;

        // STYPE with mem_ready 4 cycles after entering WRITEBACK.
        @(negedge clk);
        itype_i = STYPE;
        ir_valid_i = 1'b1;
        mem_ready_i = 1'b0;
        lat = 1; w = 0; mw = 0; pc = 0; ps = 0; done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (stage_o == 3'd1) ir_valid_i = 1'b0;
            mw += int'(mem_we_o);
            pc += int'(pc_inc_o);
            ps += int'(readin_pass_o && stage_o == 3'd2);
            if (stage_o == 3'd4) begin
                w++;
                if (w == 5) mem_ready_i = 1'b1;
            end
            if (stage_o == 3'd0) done = 1;
            else lat++;
        end
        mem_ready_i = 1'b0;
        chk("st_done", 32'(done), 32'd1);
        chk("st_latency", 32'(lat), 32'd9);
        chk("st_mem_we_cycles", 32'(mw), 32'd5);
        chk("st_pc_inc_cycles", 32'(pc), 32'd1);
        chk("st_pass", 32'(ps), 32'd1);
        chk("st_retired", retired_o, 32'd4);

        // Unrecognised itype.
        itype_i = 5'h1F;
        ir_valid_i = 1'b1;
        ill = 0; rf = 0; mw = 0; pc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (stage_o == 3'd1) ir_valid_i = 1'b0;
            ill += int'(illegal_o);
            rf += int'(rf_we_o);
            mw += int'(mem_we_o);
            pc += int'(pc_inc_o);
        end
        chk("il_illegal", 32'(ill), 32'd1);
        chk("il_rf_we", 32'(rf), 32'd0);
        chk("il_mem_we", 32'(mw), 32'd0);
        chk("il_pc_inc", 32'(pc), 32'd1);
        chk("il_retired", retired_o, 32'd4);

        // Halt raised during EXECUTE: instruction completes, then FETCH holds.
        itype_i = RTYPE;
        ir_valid_i = 1'b1;
        wait_stage(3, 10);
        halt_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j > 0) begin
                chk("hl_stage", 32'(stage_o), 32'd0);
                chk("hl_fetch_req", 32'(fetch_req_o), 32'd0);
            end
        end
        chk("hl_retired", retired_o, 32'd5);
        @(posedge clk); #2 halt_i = 1'b0;
        @(negedge clk);
        chk("hl_resume_fetch", 32'(fetch_req_o), 32'd1);
        @(negedge clk);
        chk("hl_resume_decode", 32'(stage_o), 32'd1);
        ir_valid_i = 1'b0;
        wait_stage(0, 10);
        chk("hl_retired2", retired_o, 32'd6);

        // Asynchronous reset in the middle of a store's WRITEBACK.
        itype_i = STYPE;
        ir_valid_i = 1'b1;
        wait_stage(1, 10);
        ir_valid_i = 1'b0;
        wait_stage(4, 10);
        @(negedge clk);
        #1 reset = 1'b1;
`ifdef SINGLE_STEP_EN
        step_i = 1'b0;
`endif
        #1;
        chk("ar_stage", 32'(stage_o), 32'd0);
        chk("ar_mem_we", 32'(mem_we_o), 32'd0);
        chk("ar_retired", retired_o, 32'd0);
        chk("ar_fetch_req", 32'(fetch_req_o), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        chk("ar_after_stage", 32'(stage_o), 32'd0);
        chk("ar_after_fetch", 32'(fetch_req_o), 32'd1);

`ifdef SINGLE_STEP_EN
        itype_i = RTYPE;
        ir_valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("ss_wait", 32'(stage_o), 32'd0);
        end
        pulse_step();
        wait_stage(1, 5);
        wait_stage(0, 10);
        chk("ss_one", retired_o, 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ss_hold", 32'(stage_o), 32'd0);
        end
        pulse_step();
        wait_stage(1, 5);
        pulse_step();
        pulse_step();
        wait_stage(0, 10);
        wait_stage(1, 5);
        wait_stage(0, 10);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ss_hold2", 32'(stage_o), 32'd0);
        end
        chk("ss_three", retired_o, 32'd3);
        ir_valid_i = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
